// File: rtl/slc3_mem_pkg.sv
// slc3_mem_pkg: shared types and constants for the SLC-3 memory controller slice.
//   mem_state_t      - controller FSM states
//   IO_ADDR_DEFAULT  - word address decoded as memory-mapped I/O
package slc3_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WHOLD,
    DONE
  } mem_state_t;

  localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;

endpackage

// File: rtl/slc3_mem_ctrl_if.sv
// slc3_mem_ctrl_if: req/done handshake between the SLC-3 control unit and the
// memory controller.
//   req   - request valid (master -> slave)
//   we    - 1 = write, 0 = read (master -> slave)
//   addr  - word address, MAR (master -> slave)
//   wdata - write data, MDR (master -> slave)
//   rdata - registered read data (slave -> master)
//   done  - one-cycle completion pulse (slave -> master)
//   busy  - controller not idle (slave -> master)
interface slc3_mem_ctrl_if;

  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        done;
  logic        busy;

  modport master (
    output req, we, addr, wdata,
    input  rdata, done, busy
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, done, busy
  );

endinterface

// File: rtl/slc3_io_regs.sv
// slc3_io_regs: memory-mapped I/O registers of the SLC-3 memory controller.
//   i_clk      - system clock
//   i_rst_n    - synchronous active-low reset
//   i_io_sel   - strobe: the request being accepted this cycle targets I/O
//   i_we       - request is a write
//   i_wdata    - write data for the hex-display register
//   i_switches - board switches
//   i_sram_dq  - data from the SRAM pad
//   o_hex      - hex-display register
//   o_rd_mux   - read data source: switches when I/O is selected, else SRAM
module slc3_io_regs (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_io_sel,
  input  logic        i_we,
  input  logic [15:0] i_wdata,
  input  logic [15:0] i_switches,
  input  logic [15:0] i_sram_dq,
  output logic [15:0] o_hex,
  output logic [15:0] o_rd_mux
);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_hex <= '0;
    end else if (i_io_sel && i_we) begin
      o_hex <= i_wdata;
    end
  end

  assign o_rd_mux = i_io_sel ? i_switches : i_sram_dq;

endmodule

// File: rtl/slc3_mem_ctrl.sv
// slc3_mem_ctrl: turns req/done handshake transactions into timed async-SRAM
// reads/writes, with one address decoded as memory-mapped I/O (switches/hex).
//   Clk, Reset   - clock; synchronous active-low reset
//   bus          - handshake (req/we/addr/wdata in, rdata/done/busy out)
//   SRAM_*_N     - active-low SRAM strobes (CE, OE, WE, UB, LB)
//   SRAM_ADDR    - registered SRAM address, addr zero-extended
//   SRAM_DQ_o    - data driven to SRAM; SRAM_DQ_oe enables the top-level tristate
//   SRAM_DQ_i    - data from the SRAM pad
//   Switches     - board switches, read at IO_ADDR
//   HEX_data     - hex-display register, written at IO_ADDR
module slc3_mem_ctrl
  import slc3_mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 3,
  parameter logic [15:0] IO_ADDR     = IO_ADDR_DEFAULT,
  parameter int unsigned SRAM_AW     = 20
) (
  input  logic               Clk,
  input  logic               Reset,
  slc3_mem_ctrl_if.slave     bus,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_WE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic [15:0]        SRAM_DQ_o,
  output logic               SRAM_DQ_oe,
  input  logic [15:0]        SRAM_DQ_i,
  input  logic [15:0]        Switches,
  output logic [15:0]        HEX_data
);

  localparam int unsigned      CNT_W    = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  generate
    if (WAIT_CYCLES < 1) begin : g_bad_wait
      $error("slc3_mem_ctrl: WAIT_CYCLES must be >= 1");
    end
  endgenerate

  mem_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_we;

  logic             w_accept;
  logic             w_io_sel;
  logic [15:0]      w_rd_mux;

  assign w_accept = (r_state == IDLE) && bus.req;
  assign w_io_sel = w_accept && (bus.addr == IO_ADDR);

  slc3_io_regs u_io_regs (
    .i_clk      (Clk),
    .i_rst_n    (Reset),
    .i_io_sel   (w_io_sel),
    .i_we       (bus.we),
    .i_wdata    (bus.wdata),
    .i_switches (Switches),
    .i_sram_dq  (SRAM_DQ_i),
    .o_hex      (HEX_data),
    .o_rd_mux   (w_rd_mux)
  );

  // Strobes, done and busy are set on the transition into the state they
  // belong to, so each output is registered yet aligned with the new state.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_we       <= 1'b0;
      bus.done   <= 1'b0;
      bus.busy   <= 1'b0;
      bus.rdata  <= '0;
      SRAM_CE_N  <= 1'b1;
      SRAM_OE_N  <= 1'b1;
      SRAM_WE_N  <= 1'b1;
      SRAM_UB_N  <= 1'b1;
      SRAM_LB_N  <= 1'b1;
      SRAM_ADDR  <= '0;
      SRAM_DQ_o  <= '0;
      SRAM_DQ_oe <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we      <= bus.we;
            SRAM_ADDR <= SRAM_AW'(bus.addr);
            bus.busy  <= 1'b1;
            if (w_io_sel) begin
              // I/O completes immediately; HEX_data is loaded by u_io_regs.
              if (!bus.we) begin
                bus.rdata <= w_rd_mux;
              end
              bus.done <= 1'b1;
              r_state  <= DONE;
            end else begin
              r_cnt      <= CNT_LOAD;
              SRAM_CE_N  <= 1'b0;
              SRAM_UB_N  <= 1'b0;
              SRAM_LB_N  <= 1'b0;
              SRAM_OE_N  <= bus.we;
              SRAM_WE_N  <= !bus.we;
              SRAM_DQ_oe <= bus.we;
              if (bus.we) begin
                SRAM_DQ_o <= bus.wdata;
              end
              r_state <= ACCESS;
            end
          end
        end

        ACCESS: begin
          if (r_cnt == '0) begin
            if (r_we) begin
              // Release WE first; CE and data stay driven for the hold cycle.
              SRAM_WE_N <= 1'b1;
              r_state   <= WHOLD;
            end else begin
              bus.rdata  <= w_rd_mux;
              bus.done   <= 1'b1;
              SRAM_CE_N  <= 1'b1;
              SRAM_OE_N  <= 1'b1;
              SRAM_UB_N  <= 1'b1;
              SRAM_LB_N  <= 1'b1;
              SRAM_DQ_oe <= 1'b0;
              r_state    <= DONE;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        WHOLD: begin
          bus.done   <= 1'b1;
          SRAM_CE_N  <= 1'b1;
          SRAM_WE_N  <= 1'b1;
          SRAM_UB_N  <= 1'b1;
          SRAM_LB_N  <= 1'b1;
          SRAM_DQ_oe <= 1'b0;
          r_state    <= DONE;
        end

        DONE: begin
          bus.busy <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

endmodule
